// File: rtl/unified_cache_core.sv
// Blocking, direct-mapped, write-through cache shared by NUM_INPUT_PORT requesters.
// One transaction at a time: round-robin grant, 1-cycle lookup, single outstanding memory request.
module unified_cache_core #(
  parameter int NUM_INPUT_PORT                     = 2,
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 165,
  parameter int MEM_PACKET_WIDTH_IN_BITS           = 165,
  parameter int ADDR_BITS                          = 32,
  parameter int BLOCK_BITS                         = 128,
  parameter int NUM_SETS                           = 16
) (
  input  logic                                                         clk_in,
  input  logic                                                         reset_in,
  input  logic [NUM_INPUT_PORT*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] input_packet_flatted_in,
  output logic [NUM_INPUT_PORT-1:0]                                    input_packet_ack_flatted_out,
  output logic [NUM_INPUT_PORT*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] output_packet_flatted_out,
  input  logic [NUM_INPUT_PORT-1:0]                                    output_packet_ack_flatted_in,
  input  logic [MEM_PACKET_WIDTH_IN_BITS-1:0]                          from_mem_packet_in,
  output logic                                                         from_mem_packet_ack_out,
  output logic [MEM_PACKET_WIDTH_IN_BITS-1:0]                          to_mem_packet_out,
  input  logic                                                         to_mem_packet_ack_in
);
  localparam int PW    = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int MW    = MEM_PACKET_WIDTH_IN_BITS;
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_BITS - IDX_W;
  localparam int PTR_W = (NUM_INPUT_PORT > 1) ? $clog2(NUM_INPUT_PORT) : 1;
  localparam int VLD_B = ADDR_BITS + BLOCK_BITS;
  localparam int WR_B  = VLD_B + 1;
  localparam int TYP_L = VLD_B + 2;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_RESP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [PTR_W-1:0]        r_ptr, r_req_port;
  logic [PW-1:0]           r_req;
  logic [BLOCK_BITS-1:0]   r_rdata;
  logic [NUM_SETS-1:0]     r_line_vld;
  logic [TAG_W-1:0]        r_tag  [NUM_SETS];
  logic [BLOCK_BITS-1:0]   r_line [NUM_SETS];
  logic [PW-1:0]           r_out  [NUM_INPUT_PORT];
  logic [NUM_INPUT_PORT-1:0] r_in_ack;
  logic                    r_mem_ack;
  logic [MW-1:0]           r_to_mem;

  logic [PW-1:0]             w_in_pkt [NUM_INPUT_PORT];
  logic [NUM_INPUT_PORT-1:0] w_elig;
  logic                      w_grant_vld;
  logic [PTR_W-1:0]          w_grant_idx;
  logic [2:0]                w_req_type;
  logic                      w_req_wr;
  logic [BLOCK_BITS-1:0]     w_req_data, w_mem_data;
  logic [ADDR_BITS-1:0]      w_req_addr;
  logic [IDX_W-1:0]          w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic                      w_hit, w_mem_vld, w_unused;

  assign w_req_type = r_req[TYP_L +: 3];
  assign w_req_wr   = r_req[WR_B];
  assign w_req_data = r_req[ADDR_BITS +: BLOCK_BITS];
  assign w_req_addr = r_req[ADDR_BITS-1:0];
  assign w_idx      = w_req_addr[IDX_W-1:0];
  assign w_tag      = w_req_addr[ADDR_BITS-1:IDX_W];
  assign w_hit      = !w_req_wr && r_line_vld[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_mem_vld  = from_mem_packet_in[VLD_B];
  assign w_mem_data = from_mem_packet_in[ADDR_BITS +: BLOCK_BITS];
  assign w_unused   = ^{r_req[VLD_B], from_mem_packet_in[WR_B +: 4], from_mem_packet_in[ADDR_BITS-1:0]};

  // A port holding an unconsumed response is skipped so its register is never overwritten.
  always_comb begin
    int c;
    c           = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_INPUT_PORT; k++) begin
      c = (int'(r_ptr) + k) % NUM_INPUT_PORT;
      if (!w_grant_vld && w_elig[PTR_W'(c)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = PTR_W'(c);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_grant_vld) w_state_nxt = S_LOOKUP;
      S_LOOKUP:   w_state_nxt = w_hit ? S_RESP : S_MEM_REQ;
      S_MEM_REQ:  if (to_mem_packet_ack_in) w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: if (w_mem_vld) w_state_nxt = S_RESP;
      S_RESP:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_req_port <= '0;
      r_req      <= '0;
      r_rdata    <= '0;
      r_in_ack   <= '0;
      r_mem_ack  <= 1'b0;
      r_to_mem   <= '0;
      r_line_vld <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_ack  <= '0;
      r_mem_ack <= 1'b0;
      case (r_state)
        S_IDLE: if (w_grant_vld) begin
          r_in_ack   <= NUM_INPUT_PORT'(1) << w_grant_idx;
          r_req      <= w_in_pkt[w_grant_idx];
          r_req_port <= w_grant_idx;
          r_ptr      <= (w_grant_idx == PTR_W'(NUM_INPUT_PORT-1)) ? '0 : w_grant_idx + PTR_W'(1);
        end
        S_LOOKUP: begin
          if (w_hit) r_rdata <= r_line[w_idx];
          else r_to_mem <= MW'({w_req_type, w_req_wr, 1'b1,
                                (w_req_wr ? w_req_data : {BLOCK_BITS{1'b0}}), w_req_addr});
        end
        S_MEM_REQ: if (to_mem_packet_ack_in) r_to_mem <= '0;
        S_MEM_WAIT: if (w_mem_vld) begin
          r_mem_ack         <= 1'b1;
          r_line_vld[w_idx] <= 1'b1;
          r_rdata           <= w_req_wr ? w_req_data : w_mem_data;
        end
        default: ;
      endcase
    end
  end

  // Writes allocate too, so a write-through line always mirrors memory.
  always_ff @(posedge clk_in) begin
    if (r_state == S_MEM_WAIT && w_mem_vld) begin
      r_tag[w_idx]  <= w_tag;
      r_line[w_idx] <= w_req_wr ? w_req_data : w_mem_data;
    end
  end

  for (genvar g = 0; g < NUM_INPUT_PORT; g++) begin : g_port
    assign w_in_pkt[g] = input_packet_flatted_in[g*PW +: PW];
    assign w_elig[g]   = input_packet_flatted_in[g*PW + VLD_B] & ~r_out[g][VLD_B];
    assign output_packet_flatted_out[g*PW +: PW] = r_out[g];

    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in)
        r_out[g] <= '0;
      else if (r_state == S_RESP && r_req_port == PTR_W'(g))
        r_out[g] <= PW'({w_req_type, w_req_wr, 1'b1, r_rdata, w_req_addr});
      else if (output_packet_ack_flatted_in[g])
        r_out[g] <= '0;
    end
  end

  assign input_packet_ack_flatted_out = r_in_ack;
  assign from_mem_packet_ack_out      = r_mem_ack;
  assign to_mem_packet_out            = r_to_mem;

endmodule

// File: tb/tb_unified_cache_core.sv
// Directed bench for unified_cache_core: vector table of single requests, plus reset,
// stray memory response and two-port round-robin sequences against a behavioural memory.
module tb_unified_cache_core;
  localparam int PW = 165;

  logic            clk = 1'b0;
  logic            rst;
  logic [PW-1:0]   in_pkt [2];
  logic [2*PW-1:0] in_flat;
  logic [1:0]      in_ack;
  logic [2*PW-1:0] out_flat;
  logic [1:0]      out_ack;
  logic [PW-1:0]   from_mem, to_mem;
  logic            from_mem_ack, to_mem_ack;

  int n_cmp = 0;
  int n_err = 0;
  int mem_delay = 0;
  int mem_txn = 0;
  logic [PW-1:0]  last_mem;
  logic [127:0]   mem_model [logic [31:0]];
  int gq[$];

  assign in_flat = {in_pkt[1], in_pkt[0]};

  always #5 clk = ~clk;

  unified_cache_core #(
    .NUM_INPUT_PORT(2), .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(PW), .MEM_PACKET_WIDTH_IN_BITS(PW),
    .ADDR_BITS(32), .BLOCK_BITS(128), .NUM_SETS(16)
  ) dut (
    .clk_in(clk),
    .reset_in(rst),
    .input_packet_flatted_in(in_flat),
    .input_packet_ack_flatted_out(in_ack),
    .output_packet_flatted_out(out_flat),
    .output_packet_ack_flatted_in(out_ack),
    .from_mem_packet_in(from_mem),
    .from_mem_packet_ack_out(from_mem_ack),
    .to_mem_packet_out(to_mem),
    .to_mem_packet_ack_in(to_mem_ack)
  );

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] out_pkt(input int p);
    return out_flat[p*PW +: PW];
  endfunction

  // Behavioural memory: default content of block a is a itself.
  initial begin : mem_resp
    logic [PW-1:0]  cap, rsp;
    logic [127:0]   d;
    int             n;
    to_mem_ack = 1'b0;
    from_mem   = '0;
    forever begin
      @(negedge clk);
      if (to_mem[160] && !rst) begin
        cap = to_mem;
        mem_txn++;
        last_mem = cap;
        for (int i = 0; i < mem_delay; i++) begin
          @(negedge clk);
          chk("to_mem_stable", to_mem, cap);
        end
        to_mem_ack = 1'b1;
        @(negedge clk);
        to_mem_ack = 1'b0;
        chk("to_mem_clear", to_mem, '0);
        if (cap[161]) mem_model[cap[31:0]] = cap[159:32];
        d = mem_model.exists(cap[31:0]) ? mem_model[cap[31:0]] : 128'(cap[31:0]);
        rsp = {cap[164:162], cap[161], 1'b1, d, cap[31:0]};
        @(negedge clk);
        from_mem = rsp;
        n = 0;
        do begin @(negedge clk); n++; end while (!from_mem_ack && n < 50);
        chk("from_mem_ack", PW'(from_mem_ack), PW'(1));
        from_mem = '0;
      end
    end
  end

  task automatic do_req(input int p, input logic [2:0] t, input logic w, input logic [31:0] a,
                        input logic [127:0] d, output logic [PW-1:0] resp, output int lat);
    int n;
    @(negedge clk);
    in_pkt[p] = {t, w, 1'b1, d, a};
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ack[p] && n < 100);
    chk("req_ack", PW'(in_ack[p]), PW'(1));
    in_pkt[p] = '0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_flat[p*PW+160] && lat < 500);
    resp = out_pkt(p);
    @(negedge clk);
    chk("resp_held", out_pkt(p), resp);
    out_ack[p] = 1'b1;
    @(negedge clk);
    out_ack[p] = 1'b0;
    chk("resp_clear", out_pkt(p), '0);
  endtask

  task automatic rr_drive(input int p);
    int n;
    for (int k = 0; k < 4; k++) begin
      in_pkt[p] = {3'b000, 1'b0, 1'b1, 128'h0, 32'h100 * (p + 1) + k};
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ack[p] && n < 400);
      chk("rr_ack", PW'(in_ack[p]), PW'(1));
      gq.push_back(p);
    end
    in_pkt[p] = '0;
  endtask

  task automatic rr_collect(input int p);
    int got, n;
    logic [31:0] a;
    got = 0;
    n = 0;
    while (got < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      out_ack[p] = 1'b0;
      if (out_flat[p*PW+160]) begin
        a = 32'h100 * (p + 1) + got;
        chk("rr_data", out_pkt(p), {3'b000, 1'b0, 1'b1, 128'(a), a});
        out_ack[p] = 1'b1;
        got++;
      end
    end
    @(negedge clk);
    out_ack[p] = 1'b0;
    chk("rr_resp_count", PW'(got), PW'(4));
  endtask

  typedef struct {
    int           port;
    logic [2:0]   typ;
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         miss;
    logic [127:0] exp;
  } vec_t;

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 60000 cycles, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t          vt[12];
    logic [PW-1:0] resp;
    int            lat, m0, cnt0, cnt1;
    logic          seen;

    vt[0]  = '{1, 3'b000, 1'b0, 32'h0000_0001, 128'h0,        1'b1, 128'h1};
    vt[1]  = '{1, 3'b000, 1'b0, 32'h0000_0001, 128'h0,        1'b0, 128'h1};
    vt[2]  = '{0, 3'b100, 1'b1, 32'h0000_1001, 128'hAB,       1'b1, 128'hAB};
    vt[3]  = '{0, 3'b000, 1'b0, 32'h0000_1001, 128'h0,        1'b0, 128'hAB};
    vt[4]  = '{0, 3'b000, 1'b0, 32'h0000_0001, 128'h0,        1'b1, 128'h1};
    vt[5]  = '{1, 3'b000, 1'b0, 32'h0000_0011, 128'h0,        1'b1, 128'h11};
    vt[6]  = '{0, 3'b000, 1'b0, 32'h0000_0001, 128'h0,        1'b1, 128'h1};
    vt[7]  = '{1, 3'b011, 1'b0, 32'h0000_002A, 128'h0,        1'b1, 128'h2A};
    vt[8]  = '{1, 3'b011, 1'b0, 32'h0000_002A, 128'h0,        1'b0, 128'h2A};
    vt[9]  = '{0, 3'b001, 1'b1, 32'h0000_0005, 128'hDEADBEEF, 1'b1, 128'hDEADBEEF};
    vt[10] = '{1, 3'b010, 1'b0, 32'h0000_0005, 128'h0,        1'b0, 128'hDEADBEEF};
    vt[11] = '{0, 3'b000, 1'b0, 32'h0000_1001, 128'h0,        1'b1, 128'hAB};

    rst       = 1'b1;
    in_pkt[0] = '0;
    in_pkt[1] = '0;
    out_ack   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out0", out_pkt(0), '0);
    chk("rst_out1", out_pkt(1), '0);
    chk("rst_to_mem", to_mem, '0);
    chk("rst_acks", PW'({in_ack, from_mem_ack}), '0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | (|in_ack) | out_flat[160] | out_flat[PW+160] | to_mem[160];
    end
    chk("idle_quiet", PW'(seen), '0);

    // Stray memory response while idle must be neither acked nor forwarded.
    from_mem = {3'b000, 1'b0, 1'b1, 128'h55, 32'h7};
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | from_mem_ack | out_flat[160] | out_flat[PW+160];
    end
    from_mem = '0;
    chk("stray_mem_ignored", PW'(seen), '0);

    for (int i = 0; i < 12; i++) begin
      mem_delay = i % 3;
      m0 = mem_txn;
      do_req(vt[i].port, vt[i].typ, vt[i].wr, vt[i].addr, vt[i].data, resp, lat);
      chk($sformatf("v%0d_resp", i), resp, {vt[i].typ, vt[i].wr, 1'b1, vt[i].exp, vt[i].addr});
      chk($sformatf("v%0d_mem_txn", i), PW'(mem_txn - m0), PW'(vt[i].miss));
      if (vt[i].miss)
        chk($sformatf("v%0d_to_mem", i), last_mem,
            {vt[i].typ, vt[i].wr, 1'b1, (vt[i].wr ? vt[i].data : 128'h0), vt[i].addr});
      else
        chk($sformatf("v%0d_hit_latency", i), PW'(lat), PW'(2));
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_to_mem", to_mem, '0);

    mem_delay = 6;
    fork
      rr_drive(0);
      rr_drive(1);
      rr_collect(0);
      rr_collect(1);
    join
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < gq.size(); k++) begin
      if (gq[k] == 0) cnt0++;
      else cnt1++;
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_order%0d", k), PW'((k < gq.size()) ? gq[k] : 9), PW'(k % 2));
    chk("rr_port0_grants", PW'(cnt0), PW'(4));
    chk("rr_port1_grants", PW'(cnt1), PW'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
